demux1_4_seq: RTL and testbench
===============================

// Module: demux1_4_seq
//
// PURPOSE
// - Registered 1-to-4 demultiplexer; the receive-side counterpart of the 4:1 mux.
// - Routes data_in to one of four lane registers.
// - Lane choice: the explicit sel_in (manual mode), or an internal round-robin pointer (auto mode).
// - In auto mode, each four consecutive accepted words reassemble a frame that was
//   serialised by a mux sweeping sel 0..3.
//
// PARAMETERS
// - WIDTH  1  bits per lane word (data_in width)
//
// PORTS
// - clk             input   1        rising-edge clock
// - rst             input   1        synchronous active-high reset
// - data_in         input   WIDTH    word to route
// - valid_in        input   1        data_in valid this cycle (accept strobe)
// - sel_in          input   2        target lane in manual mode (auto_in=0)
// - auto_in         input   1        1: internal pointer selects lane; 0: sel_in selects
// - y_out           output  4*WIDTH  lane registers; lane k = y_out[k*WIDTH +: WIDTH]
// - lane_valid_out  output  4        one-hot pulse, 1 cycle: lane k written last edge
// - frame_valid_out output  1        1-cycle pulse: auto-mode frame (lanes 0..3) complete
// - ptr_out         output  2        current auto-mode pointer (next lane to be written)
//
// BEHAVIOUR
// - Reset:
//   - Synchronous, active-high, highest priority.
//   - y_out, lane_valid_out, frame_valid_out, ptr_out all go to 0 on the first edge with rst=1.
//   - Reset asserted mid-frame discards the partial frame; the pointer restarts at 0.
// - Accept:
//   - A word is accepted on a clk edge with valid_in=1 and rst=0.
//   - valid_in=0: lanes hold, lane_valid_out=0, pointer unchanged.
// - Lane select:
//   - lane = auto_in ? ptr : sel_in, sampled on the same edge as data_in.
// - Latency:
//   - 1 cycle. The word appears on its lane slice of y_out after the accepting edge.
//   - lane_valid_out[lane]=1 for exactly that following cycle.
// - Auto pointer (2-bit counter, states P0..P3):
//   - Advances by 1 on each accepted word with auto_in=1.
//   - Wraps P3 -> P0.
//   - frame_valid_out=1 in the cycle after the word written to lane 3 (same cycle as lane_valid_out[3]).
// - Mode change:
//   - auto_in 0->1 (edge-detected against the registered previous value) forces the pointer to 0 that edge.
//   - A word accepted on that same edge goes to lane 0, and the pointer becomes 1.
// - Manual mode:
//   - Pointer holds its value; frame_valid_out is never asserted.
// - Back-to-back:
//   - valid_in may be held high indefinitely, accepting one word per cycle with no bubbles.
//   - In auto mode a frame completes every 4 cycles.
// - Combinational inputs:
//   - No combinational path from any input to any output; all outputs are registers.
//
// CONFIGURATION
// - DEMUX_ZERO_UNSEL_EN:
//   - Defined: on every accepted word, unselected lanes are cleared to 0 (strict demux semantics:
//     only the addressed lane is nonzero).
//   - Undefined (default): unselected lanes hold their previous contents.
//   - lane_valid_out, frame_valid_out and ptr_out behave identically in both builds.
//
// TESTING
// - Reset:
//   - Drive rst=1 for 2 cycles with valid_in=1 and data_in=1.
//   - Required: y_out=4'b0000, lane_valid_out=0, frame_valid_out=0, ptr_out=0.
// - Manual routing (WIDTH=1, auto_in=0):
//   - Accept (data_in=1, sel_in=2) -> y_out=4'b0100 and lane_valid_out=4'b0100 one cycle later.
//   - Then accept (1, sel 0) -> y_out=4'b0101 (default build) or 4'b0001 (DEMUX_ZERO_UNSEL_EN).
// - Auto frame:
//   - auto_in=1; stream 1,0,1,1 on consecutive cycles.
//   - Required: y_out=4'b1101 after the 4th edge; frame_valid_out high for exactly 1 cycle;
//     ptr_out sequence 1,2,3,0.
// - Gaps:
//   - Auto mode, stream 1,-,0,-,-,1,1 ('-' = valid_in=0).
//   - Required: pointer advances only on accepted words; frame_valid_out fires once, after the 4th accepted word.
// - Mode switch / reset mid-frame:
//   - Accept 2 words in auto mode, drop auto_in for 1 cycle, raise it again, accept 1 word.
//   - Required: that word lands in lane 0 and ptr_out=1.
//   - Repeat with rst pulsed after 2 words: ptr_out=0 and y_out=0.
// - Bubble-free throughput:
//   - valid_in=1 for 12 cycles in auto mode.
//   - Required: exactly 3 frame_valid_out pulses, spaced 4 cycles apart.

Source files
------------

// File: rtl/demux1_4_seq.sv
// Registered 1-to-4 demultiplexer with manual (sel_in) or round-robin (auto) lane selection.
// Build option: define DEMUX_ZERO_UNSEL_EN to clear unselected lanes on every accepted word.
module demux1_4_seq #(
   parameter int WIDTH = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     data_in,
   input  logic                 valid_in,
   input  logic [1:0]           sel_in,
   input  logic                 auto_in,
   output logic [4*WIDTH-1:0]   y_out,
   output logic [3:0]           lane_valid_out,
   output logic                 frame_valid_out,
   output logic [1:0]           ptr_out
);

   logic             auto_q;
   logic             auto_rise;
   logic [1:0]       ptr_eff;
   logic [1:0]       lane;
   logic [3:0]       lane_oh;

   // Entering auto mode restarts the frame at lane 0 on the same edge.
   always_comb begin
      auto_rise = auto_in & ~auto_q;
      ptr_eff   = auto_rise ? 2'd0 : ptr_out;
      lane      = auto_in ? ptr_eff : sel_in;
      lane_oh   = 4'b0001 << lane;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         y_out           <= '0;
         lane_valid_out  <= '0;
         frame_valid_out <= 1'b0;
         ptr_out         <= 2'd0;
         auto_q          <= 1'b0;
      end else begin
         auto_q <= auto_in;
         if (valid_in) begin
            for (int k = 0; k < 4; k++) begin
               if (lane_oh[k]) begin
                  y_out[k*WIDTH +: WIDTH] <= data_in;
               end else begin
`ifdef DEMUX_ZERO_UNSEL_EN
                  y_out[k*WIDTH +: WIDTH] <= '0;
`else
                  y_out[k*WIDTH +: WIDTH] <= y_out[k*WIDTH +: WIDTH];
`endif
               end
            end
            lane_valid_out  <= lane_oh;
            frame_valid_out <= auto_in && (lane == 2'd3);
            ptr_out         <= auto_in ? ptr_eff + 2'd1 : ptr_eff;
         end else begin
            lane_valid_out  <= 4'b0000;
            frame_valid_out <= 1'b0;
            ptr_out         <= ptr_eff;
         end
      end
   end

endmodule

// File: tb/tb_demux1_4_seq.sv
// Directed bench for demux1_4_seq (WIDTH=1) with hand-computed expectations.
module tb_demux1_4_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic [0:0] data_in;
   logic       valid_in;
   logic [1:0] sel_in;
   logic       auto_in;
   logic [3:0] y_out;
   logic [3:0] lane_valid_out;
   logic       frame_valid_out;
   logic [1:0] ptr_out;

   int checks = 0;
   int failures = 0;
   int fv_count;
   int fv_pos [3];

   demux1_4_seq #(.WIDTH(1)) dut (
      .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
      .sel_in(sel_in), .auto_in(auto_in), .y_out(y_out),
      .lane_valid_out(lane_valid_out), .frame_valid_out(frame_valid_out),
      .ptr_out(ptr_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs, clock it, and sample 1 time unit after the edge.
   task automatic step(input logic r, input logic v, input logic d, input logic [1:0] s, input logic a);
      rst = r; valid_in = v; data_in = d; sel_in = s; auto_in = a;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_ctl(input string tag, input logic [3:0] lv, input logic fv, input logic [1:0] p);
      chk({tag, "_lv"}, {28'd0, lane_valid_out}, {28'd0, lv});
      chk({tag, "_fv"}, {31'd0, frame_valid_out}, {31'd0, fv});
      chk({tag, "_ptr"}, {30'd0, ptr_out}, {30'd0, p});
   endtask

   initial begin
      rst = 1'b1; valid_in = 1'b1; data_in = 1'b1; sel_in = 2'd0; auto_in = 1'b0;
      #2;
      // Reset held two cycles with valid data present
      step(1, 1, 1, 0, 0);
      step(1, 1, 1, 0, 0);
      chk("rst_y", {28'd0, y_out}, 32'h0);
      chk_ctl("rst", 4'b0000, 0, 2'd0);

      // Manual routing
      step(0, 1, 1, 2, 0);
      chk("man1_y", {28'd0, y_out}, 32'b0100);
      chk_ctl("man1", 4'b0100, 0, 2'd0);
      step(0, 1, 1, 0, 0);
`ifdef DEMUX_ZERO_UNSEL_EN
      chk("man2_y", {28'd0, y_out}, 32'b0001);
`else
      chk("man2_y", {28'd0, y_out}, 32'b0101);
`endif
      chk_ctl("man2", 4'b0001, 0, 2'd0);
      step(0, 0, 0, 3, 0);
      chk_ctl("man_idle", 4'b0000, 0, 2'd0);

      // Auto frame 1,0,1,1
      step(0, 1, 1, 3, 1); chk_ctl("af1", 4'b0001, 0, 2'd1);
      step(0, 1, 0, 3, 1); chk_ctl("af2", 4'b0010, 0, 2'd2);
      step(0, 1, 1, 3, 1); chk_ctl("af3", 4'b0100, 0, 2'd3);
      step(0, 1, 1, 3, 1); chk_ctl("af4", 4'b1000, 1, 2'd0);
      chk("af_y", {28'd0, y_out}, 32'b1101);
      step(0, 0, 0, 3, 1); chk_ctl("af_idle", 4'b0000, 0, 2'd0);

      // Gaps: 1,-,0,-,-,1,1
      step(0, 1, 1, 0, 1); chk_ctl("g1", 4'b0001, 0, 2'd1);
      step(0, 0, 0, 0, 1); chk_ctl("g2", 4'b0000, 0, 2'd1);
      step(0, 1, 0, 0, 1); chk_ctl("g3", 4'b0010, 0, 2'd2);
      step(0, 0, 1, 0, 1); chk_ctl("g4", 4'b0000, 0, 2'd2);
      step(0, 0, 1, 0, 1); chk_ctl("g5", 4'b0000, 0, 2'd2);
      step(0, 1, 1, 0, 1); chk_ctl("g6", 4'b0100, 0, 2'd3);
      step(0, 1, 1, 0, 1); chk_ctl("g7", 4'b1000, 1, 2'd0);
      chk("g_y3", {31'd0, y_out[3]}, 32'd1);

      // Mode switch mid-frame
      step(0, 1, 0, 2, 1); chk_ctl("ms1", 4'b0001, 0, 2'd1);
      step(0, 1, 0, 2, 1); chk_ctl("ms2", 4'b0010, 0, 2'd2);
      step(0, 0, 0, 2, 0); chk_ctl("ms_drop", 4'b0000, 0, 2'd2);
      step(0, 1, 1, 2, 1); chk_ctl("ms_rise", 4'b0001, 0, 2'd1);
      chk("ms_y10", {30'd0, y_out[1:0]}, 32'b01);

      // Reset mid-frame
      step(0, 1, 1, 0, 1); chk_ctl("rm1", 4'b0010, 0, 2'd2);
      step(0, 1, 1, 0, 1); chk_ctl("rm2", 4'b0100, 0, 2'd3);
      step(1, 1, 1, 0, 1);
      chk("rm_y", {28'd0, y_out}, 32'h0);
      chk_ctl("rm_rst", 4'b0000, 0, 2'd0);
      step(0, 1, 1, 0, 1); chk_ctl("rm_after", 4'b0001, 0, 2'd1);

      // Bubble-free throughput from a clean pointer
      step(1, 0, 0, 0, 1);
      fv_count = 0;
      for (int i = 0; i < 12; i++) begin
         step(0, 1, i[0], 0, 1);
         chk($sformatf("tp_ptr%0d", i), {30'd0, ptr_out}, (i + 1) % 4);
         if (frame_valid_out === 1'b1) begin
            if (fv_count < 3) fv_pos[fv_count] = i;
            fv_count++;
         end
      end
      chk("tp_count", fv_count, 32'd3);
      if (fv_count == 3) begin
         chk("tp_pos0", fv_pos[0], 32'd3);
         chk("tp_gap1", fv_pos[1] - fv_pos[0], 32'd4);
         chk("tp_gap2", fv_pos[2] - fv_pos[1], 32'd4);
      end
      step(0, 0, 0, 0, 1); chk_ctl("tp_idle", 4'b0000, 0, 2'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
